fsm_holdoff_timer: RTL and testbench



---
 rtl/fsm_holdoff_timer.sv | 95 +++++++++
 tb/tb_fsm_holdoff_timer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fsm_holdoff_timer.sv
// Hold-off timer: counts HOLD prescaled ticks after START, then raises READY
// until the upstream controller's synchronous RESET clears it.
module fsm_holdoff_timer #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 1
) (
   input  logic             CLK,
   input  logic             N_RESET,
   input  logic             RESET,
   input  logic             START,
   input  logic [WIDTH-1:0] HOLD,
   output logic             READY,
   output logic             BUSY,
   output logic [WIDTH-1:0] REMAIN
);

   localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      COUNT = 2'b01,
      DONE  = 2'b10
   } state_t;

   state_t           state, next_state;
   logic [WIDTH-1:0] ticks, next_ticks;
   logic [15:0]      pre, next_pre;

   always_ff @(posedge CLK or negedge N_RESET) begin
      if (!N_RESET) begin
         state <= IDLE;
         ticks <= '0;
         pre   <= '0;
      end else begin
         state <= next_state;
         ticks <= next_ticks;
         pre   <= next_pre;
      end
   end

   always_comb begin
      next_state = state;
      next_ticks = ticks;
      next_pre   = pre;
      if (RESET) begin
         next_state = IDLE;
         next_ticks = '0;
         next_pre   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (START) begin
                  next_pre = '0;
                  if (HOLD == '0) begin
                     next_state = DONE;
                     next_ticks = '0;
                  end else begin
                     next_state = COUNT;
                     next_ticks = HOLD;
                  end
               end
            end
            COUNT: begin
               if (pre == PRE_LAST) begin
                  next_pre = '0;
                  // A zero count here is unreachable but is finished rather than wrapped.
                  if (ticks <= WIDTH'(1)) begin
                     next_ticks = '0;
                     next_state = DONE;
                  end else begin
                     next_ticks = ticks - WIDTH'(1);
                  end
               end else begin
                  next_pre = pre + 16'd1;
               end
            end
            DONE: begin
               next_state = DONE;
            end
            default: begin
               next_state = IDLE;
               next_ticks = '0;
               next_pre   = '0;
            end
         endcase
      end
   end

   always_comb begin
      READY  = (state == DONE);
      BUSY   = (state == COUNT);
      REMAIN = ticks;
   end

endmodule

// File: tb/tb_fsm_holdoff_timer.sv
// Directed scoreboard bench for fsm_holdoff_timer at PRESCALE=1 and PRESCALE=3.
module tb_fsm_holdoff_timer;

   typedef struct {
      int unsigned sel;
      logic [9:0]  exp;
      string       tag;
   } entry_t;

   logic       clk;
   logic       clk_en;
   logic       n_reset;
   logic       reset_a, start_a, reset_b, start_b;
   logic [7:0] hold_a, hold_b;
   logic       ready_a, busy_a, ready_b, busy_b;
   logic [7:0] remain_a, remain_b;

   entry_t sb[$];
   int     total;
   int     bad;

   fsm_holdoff_timer #(.WIDTH(8), .PRESCALE(1)) dut_a (
      .CLK(clk), .N_RESET(n_reset), .RESET(reset_a), .START(start_a), .HOLD(hold_a),
      .READY(ready_a), .BUSY(busy_a), .REMAIN(remain_a)
   );

   fsm_holdoff_timer #(.WIDTH(8), .PRESCALE(3)) dut_b (
      .CLK(clk), .N_RESET(n_reset), .RESET(reset_b), .START(start_b), .HOLD(hold_b),
      .READY(ready_b), .BUSY(busy_b), .REMAIN(remain_b)
   );

   initial begin
      clk = 1'b0;
      forever begin
         #5;
         if (clk_en) clk = ~clk;
      end
   end

   task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h (ready,busy,remain)", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] outs(input int unsigned sel);
      return (sel == 0) ? {ready_a, busy_a, remain_a} : {ready_b, busy_b, remain_b};
   endfunction

   // One clock: drive inputs on the falling edge, queue the expected post-edge outputs,
   // then pop and compare just after the rising edge.
   task automatic step(input int unsigned sel, input logic rst, input logic st,
                       input logic [7:0] hold, input logic rdy, input logic bsy,
                       input logic [7:0] rem, input string tag);
      entry_t e;
      @(negedge clk);
      reset_a = 1'b1; start_a = 1'b0;
      reset_b = 1'b1; start_b = 1'b0;
      if (sel == 0) begin
         reset_a = rst; start_a = st; hold_a = hold;
      end else begin
         reset_b = rst; start_b = st; hold_b = hold;
      end
      e.sel = sel;
      e.exp = {rdy, bsy, rem};
      e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s observed=empty-queue expected=entry", tag);
      end else begin
         e = sb.pop_front();
         check(e.tag, outs(e.sel), e.exp);
      end
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      clk_en  = 1'b1;
      n_reset = 1'b0;
      reset_a = 1'b0; start_a = 1'b0; hold_a = 8'd0;
      reset_b = 1'b0; start_b = 1'b0; hold_b = 8'd0;
      #2;
      check("reset_a", outs(0), 10'd0);
      check("reset_b", outs(1), 10'd0);
      #20;
      n_reset = 1'b1;
      step(0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, "idle_after_reset");
      step(0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, "idle_stays");

      // HOLD=5, PRESCALE=1
      step(0, 1'b0, 1'b1, 8'd5, 1'b0, 1'b1, 8'd5, "h5_k");
      for (int i = 4; i >= 1; i--)
         step(0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b1, 8'(i), "h5_count");
      step(0, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0, 8'd0, "h5_done");
      for (int i = 0; i < 20; i++)
         step(0, 1'b0, (i == 3), 8'd7, 1'b1, 1'b0, 8'd0, "h5_ready_held");
      step(0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, "h5_clear");

      // HOLD=0 goes straight to DONE
      step(0, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 8'd0, "h0_done");
      step(0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, "h0_hold");
      step(0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, "h0_clear");

      // START and RESET on one edge
      step(0, 1'b1, 1'b1, 8'd7, 1'b0, 1'b0, 8'd0, "start_reset_same");
      step(0, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0, 8'd0, "start_reset_idle");

      // HOLD=4 aborted by RESET at REMAIN=2, with an ignored START mid-count
      step(0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 8'd4, "abort_k");
      step(0, 1'b0, 1'b1, 8'd9, 1'b0, 1'b1, 8'd3, "abort_restart_ignored");
      step(0, 1'b0, 1'b0, 8'd9, 1'b0, 1'b1, 8'd2, "abort_rem2");
      step(0, 1'b1, 1'b0, 8'd9, 1'b0, 1'b0, 8'd0, "abort_reset");
      for (int i = 0; i < 5; i++)
         step(0, 1'b0, 1'b0, 8'd9, 1'b0, 1'b0, 8'd0, "abort_no_ready");

      // HOLD=4 with START pulses and HOLD=9 during the count
      step(0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b1, 8'd4, "ign_k");
      step(0, 1'b0, 1'b1, 8'd9, 1'b0, 1'b1, 8'd3, "ign_3");
      step(0, 1'b0, 1'b0, 8'd9, 1'b0, 1'b1, 8'd2, "ign_2");
      step(0, 1'b0, 1'b1, 8'd9, 1'b0, 1'b1, 8'd1, "ign_1");
      step(0, 1'b0, 1'b0, 8'd9, 1'b1, 1'b0, 8'd0, "ign_done");

      // Asynchronous reset with the clock stopped, taken from DONE
      @(negedge clk);
      clk_en = 1'b0;
      #3;
      check("pre_async_done", outs(0), {1'b1, 1'b0, 8'd0});
      n_reset = 1'b0;
      #1;
      check("async_immediate", outs(0), 10'd0);
      #3;
      n_reset = 1'b1;
      #1;
      check("async_released", outs(0), 10'd0);
      clk_en = 1'b1;
      step(0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 8'd0, "async_idle_1");
      step(0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 8'd0, "async_idle_2");

      // PRESCALE=3, HOLD=2
      step(1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, "p3_clear");
      step(1, 1'b0, 1'b1, 8'd2, 1'b0, 1'b1, 8'd2, "p3_k");
      step(1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd2, "p3_k1");
      step(1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd2, "p3_k2");
      step(1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd1, "p3_k3");
      step(1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd1, "p3_k4");
      step(1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd1, "p3_k5");
      step(1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, "p3_k6");
      step(1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, "p3_k7");

      // Closed loop as seen from the timer: controller pulses START, then aborts via RESET
      step(0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 8'd0, "loop_idle");
      step(0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b1, 8'd3, "loop_start");
      step(0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1, 8'd2, "loop_hold");
      step(0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 8'd0, "loop_abort");
      step(0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0, 8'd0, "loop_stays_idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
